// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the MEM pipeline stage:
//   - register bus widths and types (RegAddrBus / RegDataBus)
//   - ENABLE / DISABLE and ZERO_WORD constants
//   - memory op encodings (mem_op_e) and MEM-stage FSM state codes
//   - small helpers that classify an op as load/store/misaligned
// -----------------------------------------------------------------------------
package mem_access_pkg;

   localparam int REG_ADDR_W    = 5;
   localparam int REG_DATA_W    = 32;
   localparam int TIMEOUT_CNT_W = 8;

   typedef logic [REG_ADDR_W-1:0] reg_addr_bus_t;
   typedef logic [REG_DATA_W-1:0] reg_data_bus_t;

   localparam logic          ENABLE    = 1'b1;
   localparam logic          DISABLE   = 1'b0;
   localparam reg_data_bus_t ZERO_WORD = 32'h0000_0000;

   typedef enum logic [3:0] {
      MEM_NONE = 4'd0,
      MEM_LB   = 4'd1,
      MEM_LBU  = 4'd2,
      MEM_LH   = 4'd3,
      MEM_LHU  = 4'd4,
      MEM_LW   = 4'd5,
      MEM_SB   = 4'd6,
      MEM_SH   = 4'd7,
      MEM_SW   = 4'd8
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } mem_state_e;

   function automatic logic op_is_load(input mem_op_e op);
      return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
             (op == MEM_LHU) || (op == MEM_LW);
   endfunction

   function automatic logic op_is_store(input mem_op_e op);
      return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
   endfunction

   // Halfwords need an even address, words a 4-byte aligned address.
   function automatic logic op_is_misaligned(input mem_op_e op, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      case (op)
         MEM_LH, MEM_LHU, MEM_SH: mis = off[0];
         MEM_LW, MEM_SW:          mis = (off != 2'b00);
         default:                 mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// -----------------------------------------------------------------------------
// mem_lane_unit
// Purely combinational byte-lane logic for the MEM stage (little-endian).
//   mem_op     in  4   memory op code (mem_op_e encoding)
//   byte_off   in  2   low address bits of the effective address
//   st_data    in  32  store source data
//   rdata      in  32  raw bus read word
//   is_load    out 1   op is a load
//   is_store   out 1   op is a store
//   misaligned out 1   halfword/word op on an illegal boundary
//   be         out 4   byte enables (loads read the full word)
//   wdata      out 32  lane-replicated store data
//   ld_data    out 32  selected and sign/zero-extended load data
// -----------------------------------------------------------------------------
module mem_lane_unit
   import mem_access_pkg::*;
(
   input  logic [3:0]    mem_op,
   input  logic [1:0]    byte_off,
   input  reg_data_bus_t st_data,
   input  reg_data_bus_t rdata,
   output logic          is_load,
   output logic          is_store,
   output logic          misaligned,
   output logic [3:0]    be,
   output reg_data_bus_t wdata,
   output reg_data_bus_t ld_data
);

   mem_op_e       op;
   logic [7:0]    rd_byte [4];
   reg_data_bus_t st_byte_rep;
   reg_data_bus_t st_half_rep;
   logic [7:0]    sel_byte;
   logic [15:0]   sel_half;

   assign op = mem_op_e'(mem_op);

   // Slice the read word into byte lanes and replicate store data so the
   // memory only has to honour the byte enables.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte_lane
         assign rd_byte[gi]            = rdata[8*gi +: 8];
         assign st_byte_rep[8*gi +: 8] = st_data[7:0];
      end
      for (gi = 0; gi < 2; gi++) begin : g_half_lane
         assign st_half_rep[16*gi +: 16] = st_data[15:0];
      end
   endgenerate

   assign sel_byte = rd_byte[byte_off];
   assign sel_half = byte_off[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      is_load    = op_is_load(op);
      is_store   = op_is_store(op);
      misaligned = op_is_misaligned(op, byte_off);
      be         = 4'b0000;
      wdata      = st_data;
      ld_data    = ZERO_WORD;
      case (op)
         MEM_LB:  ld_data = {{24{sel_byte[7]}}, sel_byte};
         MEM_LBU: ld_data = {24'h00_0000, sel_byte};
         MEM_LH:  ld_data = {{16{sel_half[15]}}, sel_half};
         MEM_LHU: ld_data = {16'h0000, sel_half};
         MEM_LW:  ld_data = rdata;
         MEM_SB: begin
            be    = 4'b0001 << byte_off;
            wdata = st_byte_rep;
         end
         MEM_SH: begin
            be    = byte_off[1] ? 4'b1100 : 4'b0011;
            wdata = st_half_rep;
         end
         MEM_SW:  be = 4'b1111;
         default: ;
      endcase
      // Loads always fetch the whole word; lane selection happens on return.
      if (is_load) begin
         be = 4'b1111;
      end
   end

endmodule

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
// MEM stage of the 5-stage pipeline (between EX_MEM and MEM_WB). Issues
// loads/stores on a req/ack data bus, stalls the pipeline while a
// transaction is outstanding, and aborts after ACK_TIMEOUT cycles.
//   clk          in  1   pipeline clock, rising edge
//   rst          in  1   asynchronous active-low reset
//   wrn_i        in  1   register write enable from EX_MEM
//   wrAddr_i     in  5   destination register
//   wrData_i     in  32  ALU result (write data for non-loads)
//   memOp_i      in  4   memory op (mem_op_e)
//   memAddr_i    in  32  effective byte address
//   memStData_i  in  32  store source data
//   dmem_*       bus     req/we/addr/be/wdata out, rdata/ack in
//   stallreq_o   out 1   stall request to the stall controller
//   wrn_o/wrAddr_o/wrData_o  out  write-back inputs of MEM_WB
//   align_err_o  out 1   one-cycle pulse after a misaligned access
//   bus_err_o    out 1   one-cycle pulse in the DONE cycle of a timeout
// -----------------------------------------------------------------------------
module mem_access
   import mem_access_pkg::*;
#(
   parameter int ACK_TIMEOUT = 16
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          wrn_i,
   input  reg_addr_bus_t wrAddr_i,
   input  reg_data_bus_t wrData_i,
   input  logic [3:0]    memOp_i,
   input  logic [31:0]   memAddr_i,
   input  reg_data_bus_t memStData_i,
   output logic          dmem_req_o,
   output logic          dmem_we_o,
   output logic [31:0]   dmem_addr_o,
   output logic [3:0]    dmem_be_o,
   output reg_data_bus_t dmem_wdata_o,
   input  reg_data_bus_t dmem_rdata_i,
   input  logic          dmem_ack_i,
   output logic          stallreq_o,
   output logic          wrn_o,
   output reg_addr_bus_t wrAddr_o,
   output reg_data_bus_t wrData_o,
   output logic          align_err_o,
   output logic          bus_err_o
);

   localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CNT_W'(ACK_TIMEOUT - 1);

   mem_state_e                state_reg, state_next;
   logic [TIMEOUT_CNT_W-1:0] cnt_reg, cnt_next;
   reg_data_bus_t             ld_data_reg, ld_data_next;
   logic                      align_err_reg, align_err_next;
   logic                      bus_err_reg, bus_err_next;

   logic          is_load, is_store, misaligned, mem_op_valid, timeout_hit;
   logic [3:0]    lane_be;
   reg_data_bus_t lane_wdata, lane_ld_data;

   mem_lane_unit u_lane (
      .mem_op     (memOp_i),
      .byte_off   (memAddr_i[1:0]),
      .st_data    (memStData_i),
      .rdata      (dmem_rdata_i),
      .is_load    (is_load),
      .is_store   (is_store),
      .misaligned (misaligned),
      .be         (lane_be),
      .wdata      (lane_wdata),
      .ld_data    (lane_ld_data)
   );

   assign mem_op_valid = is_load | is_store;
   assign timeout_hit  = (cnt_reg == TIMEOUT_LAST);

   // Address/be/wdata follow the inputs, which the stall holds steady.
   assign dmem_addr_o  = {memAddr_i[31:2], 2'b00};
   assign dmem_we_o    = is_store;
   assign dmem_be_o    = lane_be;
   assign dmem_wdata_o = lane_wdata;
   assign align_err_o  = align_err_reg;
   assign bus_err_o    = bus_err_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         ld_data_reg   <= ZERO_WORD;
         align_err_reg <= DISABLE;
         bus_err_reg   <= DISABLE;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         ld_data_reg   <= ld_data_next;
         align_err_reg <= align_err_next;
         bus_err_reg   <= bus_err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = '0;
      ld_data_next   = ld_data_reg;
      align_err_next = DISABLE;
      bus_err_next   = DISABLE;
      dmem_req_o     = DISABLE;
      stallreq_o     = DISABLE;
      wrn_o          = wrn_i;
      wrAddr_o       = wrAddr_i;
      wrData_o       = wrData_i;

      case (state_reg)
         ST_IDLE: begin
            if (mem_op_valid) begin
               if (misaligned) begin
                  // Suppress the write-back and flag it; no bus traffic.
                  wrn_o          = DISABLE;
                  align_err_next = ENABLE;
               end else begin
                  dmem_req_o = ENABLE;
                  stallreq_o = ENABLE;
                  if (dmem_ack_i) begin
                     state_next   = ST_DONE;
                     ld_data_next = is_load ? lane_ld_data : ld_data_reg;
                  end else begin
                     state_next = ST_WAIT;
                     cnt_next   = cnt_reg + 1'b1;
                  end
               end
            end
         end

         ST_WAIT: begin
            dmem_req_o = ENABLE;
            stallreq_o = ENABLE;
            // An ack on the timeout edge still counts as a normal completion.
            if (dmem_ack_i) begin
               state_next   = ST_DONE;
               ld_data_next = is_load ? lane_ld_data : ld_data_reg;
            end else if (timeout_hit) begin
               state_next   = ST_DONE;
               bus_err_next = ENABLE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         ST_DONE: begin
            // MEM_WB latches on this edge and a new instruction arrives.
            state_next = ST_IDLE;
            if (bus_err_reg) begin
               wrn_o = DISABLE;
            end else if (is_load) begin
               wrData_o = ld_data_reg;
            end
         end

         default: state_next = ST_IDLE;
      endcase

      // Abandon any outstanding request the moment reset asserts.
      if (!rst) begin
         dmem_req_o = DISABLE;
         stallreq_o = DISABLE;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access
// Directed stimulus pushes the expected per-cycle response into a scoreboard
// queue; an independent monitor pops and compares on each falling edge.
// -----------------------------------------------------------------------------
module tb_mem_access;

   localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3,
                          OP_LHU = 4'd4, OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7,
                          OP_SW = 4'd8;

   logic        clk = 1'b0;
   logic        rst;
   logic        wrn_i;
   logic [4:0]  wrAddr_i;
   logic [31:0] wrData_i;
   logic [3:0]  memOp_i;
   logic [31:0] memAddr_i;
   logic [31:0] memStData_i;
   logic        dmem_req_o, dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_wdata_o;
   logic [31:0] dmem_rdata_i;
   logic        dmem_ack_i;
   logic        stallreq_o, wrn_o;
   logic [4:0]  wrAddr_o;
   logic [31:0] wrData_o;
   logic        align_err_o, bus_err_o;

   mem_access #(.ACK_TIMEOUT(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .wrn_i        (wrn_i),
      .wrAddr_i     (wrAddr_i),
      .wrData_i     (wrData_i),
      .memOp_i      (memOp_i),
      .memAddr_i    (memAddr_i),
      .memStData_i  (memStData_i),
      .dmem_req_o   (dmem_req_o),
      .dmem_we_o    (dmem_we_o),
      .dmem_addr_o  (dmem_addr_o),
      .dmem_be_o    (dmem_be_o),
      .dmem_wdata_o (dmem_wdata_o),
      .dmem_rdata_i (dmem_rdata_i),
      .dmem_ack_i   (dmem_ack_i),
      .stallreq_o   (stallreq_o),
      .wrn_o        (wrn_o),
      .wrAddr_o     (wrAddr_o),
      .wrData_o     (wrData_o),
      .align_err_o  (align_err_o),
      .bus_err_o    (bus_err_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] tag;
      logic        req, stall, wrn, align, bus, chk_bus, chk_wdata, we;
      logic [4:0]  wraddr;
      logic [31:0] wrdata, addr, wdata;
      logic [3:0]  be;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   step_no  = 0;

   task automatic check(input int tag, input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL step %0d %s: got 0x%08h expected 0x%08h", tag, nm, act, exp);
      end
   endtask

   // Monitor: one expected record per cycle, compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check(e.tag, "dmem_req", {31'd0, dmem_req_o}, {31'd0, e.req});
            check(e.tag, "stallreq", {31'd0, stallreq_o}, {31'd0, e.stall});
            check(e.tag, "wrn", {31'd0, wrn_o}, {31'd0, e.wrn});
            check(e.tag, "wrAddr", {27'd0, wrAddr_o}, {27'd0, e.wraddr});
            check(e.tag, "wrData", wrData_o, e.wrdata);
            check(e.tag, "align_err", {31'd0, align_err_o}, {31'd0, e.align});
            check(e.tag, "bus_err", {31'd0, bus_err_o}, {31'd0, e.bus});
            if (e.chk_bus) begin
               check(e.tag, "dmem_we", {31'd0, dmem_we_o}, {31'd0, e.we});
               check(e.tag, "dmem_addr", dmem_addr_o, e.addr);
               check(e.tag, "dmem_be", {28'd0, dmem_be_o}, {28'd0, e.be});
               if (e.chk_wdata)
                  check(e.tag, "dmem_wdata", dmem_wdata_o, e.wdata);
            end
            $display("step %0d checked: req=%0b stall=%0b wrn=%0b wrData=0x%08h",
                     e.tag, dmem_req_o, stallreq_o, wrn_o, wrData_o);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      step_no++;
   endtask

   // Cycle with no bus-side checks.
   task automatic cyc(input logic req, input logic stall, input logic wrn,
                      input logic [31:0] wrdata, input logic align, input logic bus);
      exp_t e;
      e = '0;
      e.tag = 16'(step_no); e.req = req; e.stall = stall; e.wrn = wrn;
      e.wraddr = wrAddr_i; e.wrdata = wrdata; e.align = align; e.bus = bus;
      sb_q.push_back(e);
      tick();
   endtask

   // Cycle with an outstanding request and checked bus signals.
   task automatic cyc_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic wrn, input logic [31:0] wrdata);
      exp_t e;
      e = '0;
      e.tag = 16'(step_no); e.req = 1'b1; e.stall = 1'b1; e.wrn = wrn;
      e.wraddr = wrAddr_i; e.wrdata = wrdata; e.chk_bus = 1'b1; e.chk_wdata = we;
      e.we = we; e.addr = addr; e.be = be; e.wdata = wdata;
      sb_q.push_back(e);
      tick();
   endtask

   task automatic set_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] st,
                         input logic wrn, input logic [4:0] wra, input logic [31:0] wrd);
      memOp_i = op; memAddr_i = addr; memStData_i = st;
      wrn_i = wrn; wrAddr_i = wra; wrData_i = wrd;
   endtask

   // Single-cycle-ack vectors: op, addr, store data, read data, we, word addr,
   // be, wdata, expected DONE write data (hand-computed).
   logic [3:0]  t_op    [9];
   logic [31:0] t_addr  [9];
   logic [31:0] t_st    [9];
   logic [31:0] t_rd    [9];
   logic        t_we    [9];
   logic [31:0] t_waddr [9];
   logic [3:0]  t_be    [9];
   logic [31:0] t_wdata [9];
   logic [31:0] t_res   [9];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      t_op    = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LB, OP_LW, OP_SB, OP_SW, OP_SH};
      t_addr  = '{32'h103, 32'h103, 32'h002, 32'h000, 32'h101, 32'h010, 32'h301, 32'h404, 32'h000};
      t_st    = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1234_56A5, 32'h89AB_CDEF, 32'h0000_BEEF};
      t_rd    = '{32'h80FF_0000, 32'h80FF_0000, 32'h8001_7FFF, 32'h8001_7FFF, 32'h1234_7F56,
                  32'hCAFE_BABE, 32'h0, 32'h0, 32'h0};
      t_we    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      t_waddr = '{32'h100, 32'h100, 32'h000, 32'h000, 32'h100, 32'h010, 32'h300, 32'h404, 32'h000};
      t_be    = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'b0010, 4'hF, 4'b0011};
      t_wdata = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hA5A5_A5A5, 32'h89AB_CDEF, 32'hBEEF_BEEF};
      t_res   = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_7FFF, 32'h0000_007F,
                  32'hCAFE_BABE, 32'hA000_0006, 32'hA000_0007, 32'hA000_0008};

      rst = 1'b0;
      set_op(OP_NONE, 32'h0, 32'h0, 1'b1, 5'd5, 32'h1234);
      dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
      @(posedge clk); #1;

      // Reset state, then plain ALU pass-through.
      cyc(1'b0, 1'b0, 1'b1, 32'h1234, 1'b0, 1'b0);
      rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b1, 32'h1234, 1'b0, 1'b0);

      // Zero-wait accesses: one stall cycle, then DONE.
      for (int i = 0; i < 9; i++) begin
         set_op(t_op[i], t_addr[i], t_st[i], ~t_we[i], 5'(i + 1), 32'hA000_0000 + 32'(i));
         dmem_rdata_i = t_rd[i];
         dmem_ack_i   = 1'b1;
         cyc_bus(t_we[i], t_waddr[i], t_be[i], t_wdata[i], ~t_we[i], 32'hA000_0000 + 32'(i));
         dmem_ack_i   = 1'b0;
         dmem_rdata_i = 32'hDEAD_BEEF;
         cyc(1'b0, 1'b0, ~t_we[i], t_res[i], 1'b0, 1'b0);
      end

      // SH with ack after three wait cycles: bus held for four cycles.
      set_op(OP_SH, 32'h202, 32'hABCD_5678, 1'b0, 5'd3, 32'h202);
      for (int k = 0; k < 4; k++) begin
         dmem_ack_i = (k == 3);
         cyc_bus(1'b1, 32'h200, 4'b1100, 32'h5678_5678, 1'b0, 32'h202);
      end
      dmem_ack_i = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 32'h202, 1'b0, 1'b0);

      // Misaligned LW and LH: no request, wrn suppressed, pulse next cycle.
      set_op(OP_LW, 32'h006, 32'h0, 1'b1, 5'd4, 32'h6);
      cyc(1'b0, 1'b0, 1'b0, 32'h6, 1'b0, 1'b0);
      set_op(OP_NONE, 32'h0, 32'h0, 1'b1, 5'd4, 32'h6);
      cyc(1'b0, 1'b0, 1'b1, 32'h6, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 32'h6, 1'b0, 1'b0);
      set_op(OP_LH, 32'h101, 32'h0, 1'b1, 5'd6, 32'h7);
      cyc(1'b0, 1'b0, 1'b0, 32'h7, 1'b0, 1'b0);
      set_op(OP_NONE, 32'h0, 32'h0, 1'b1, 5'd6, 32'h7);
      cyc(1'b0, 1'b0, 1'b1, 32'h7, 1'b1, 1'b0);

      // Timeout: 16 request cycles, then DONE with bus_err and wrn forced low.
      set_op(OP_LW, 32'h40, 32'h0, 1'b1, 5'd9, 32'h55);
      repeat (16) cyc_bus(1'b0, 32'h40, 4'hF, 32'h0, 1'b1, 32'h55);
      cyc(1'b0, 1'b0, 1'b0, 32'h55, 1'b0, 1'b1);
      set_op(OP_NONE, 32'h0, 32'h0, 1'b1, 5'd9, 32'h55);
      cyc(1'b0, 1'b0, 1'b1, 32'h55, 1'b0, 1'b0);

      // Ack on the timeout edge wins: normal completion.
      set_op(OP_LW, 32'h80, 32'h0, 1'b1, 5'd10, 32'h66);
      dmem_rdata_i = 32'h1122_3344;
      for (int k = 0; k < 16; k++) begin
         dmem_ack_i = (k == 15);
         cyc_bus(1'b0, 32'h80, 4'hF, 32'h0, 1'b1, 32'h66);
      end
      dmem_ack_i = 1'b0;
      cyc(1'b0, 1'b0, 1'b1, 32'h1122_3344, 1'b0, 1'b0);

      // Reset in WAIT cycle 2 drops the request without waiting for a clock.
      set_op(OP_LW, 32'h10, 32'h0, 1'b1, 5'd11, 32'h77);
      cyc_bus(1'b0, 32'h10, 4'hF, 32'h0, 1'b1, 32'h77);
      cyc_bus(1'b0, 32'h10, 4'hF, 32'h0, 1'b1, 32'h77);
      rst = 1'b0;
      cyc(1'b0, 1'b0, 1'b1, 32'h77, 1'b0, 1'b0);
      set_op(OP_NONE, 32'h0, 32'h0, 1'b1, 5'd11, 32'h77);
      cyc(1'b0, 1'b0, 1'b1, 32'h77, 1'b0, 1'b0);
      rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b1, 32'h77, 1'b0, 1'b0);
      set_op(OP_LW, 32'h10, 32'h0, 1'b1, 5'd12, 32'h88);
      dmem_rdata_i = 32'h0BAD_F00D;
      dmem_ack_i   = 1'b1;
      cyc_bus(1'b0, 32'h10, 4'hF, 32'h0, 1'b1, 32'h88);
      dmem_ack_i = 1'b0;
      cyc(1'b0, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, 1'b0);
      set_op(OP_NONE, 32'h0, 32'h0, 1'b1, 5'd12, 32'h88);
      cyc(1'b0, 1'b0, 1'b1, 32'h88, 1'b0, 1'b0);

      @(negedge clk); #1;
      check(step_no, "scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
